mips_alu: RTL and testbench

//   Registered MIPS-style integer ALU for the execute stage.

---
 rtl/mips_alu_if.sv | 27 ++
 rtl/mips_alu.sv | 93 +++++++++
 tb/tb_mips_alu.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_alu_if.sv
// mips_alu_if: operand/control bundle into the ALU and registered result bundle out.
// Latency: n/a (wires only). Backpressure: none, the consumer takes one op per cycle.
// Ports: in_valid/alu_ctl/a/b flow master->slave; out_valid/alu_out/zero/overflow flow slave->master.
interface mips_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             overflow;

  // Execute-stage driver side (register file / immediate mux + ALU control decoder).
  modport master (
    output in_valid, alu_ctl, a, b,
    input  out_valid, alu_out, zero, overflow
  );

  // ALU side.
  modport slave (
    input  in_valid, alu_ctl, a, b,
    output out_valid, alu_out, zero, overflow
  );
endinterface

// File: rtl/mips_alu.sv
// mips_alu: registered MIPS integer ALU (AND/OR/ADD/SUB/SLT/NOR) with zero and signed-overflow flags.
// Latency: 1 cycle from an in_valid edge to out_valid; results hold while in_valid is low.
// Backpressure: none; a new operation is accepted every cycle.
// Ports: clk (rising edge), rst_n (async active-low), alu_if (slave modport of mips_alu_if).
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mips_alu_if.slave   alu_if
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_overflow;

  assign w_sum  = alu_if.a + alu_if.b;
  assign w_diff = alu_if.a - alu_if.b;

  // SLT is a direct signed compare rather than the sign of a-b, so it stays
  // correct when the subtraction itself overflows.
  assign w_slt = $signed(alu_if.a) < $signed(alu_if.b);

  // ADD overflows when both operands share a sign that the sum does not.
  assign w_add_ovf = (alu_if.a[MSB] == alu_if.b[MSB]) && (w_sum[MSB] != alu_if.a[MSB]);
  // SUB overflows when the operand signs differ and the result sign leaves a's sign.
  assign w_sub_ovf = (alu_if.a[MSB] != alu_if.b[MSB]) && (w_diff[MSB] != alu_if.a[MSB]);

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (alu_if.alu_ctl)
      CTL_AND: w_result = alu_if.a & alu_if.b;
      CTL_OR:  w_result = alu_if.a | alu_if.b;
      CTL_ADD: begin
        w_result = w_sum;
        w_ovf    = w_add_ovf;
      end
      CTL_SUB: begin
        w_result = w_diff;
        w_ovf    = w_sub_ovf;
      end
      CTL_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
      CTL_NOR: w_result = ~(alu_if.a | alu_if.b);
      default: begin
        w_result = '0;
        w_ovf    = 1'b0;
      end
    endcase
  end

  // The zero flag is derived from the fresh result and registered alongside it,
  // so it can never disagree with alu_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_zero      <= 1'b1;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= alu_if.in_valid;
      if (alu_if.in_valid) begin
        r_alu_out  <= w_result;
        r_zero     <= (w_result == '0);
        r_overflow <= w_ovf;
      end
    end
  end

  assign alu_if.out_valid = r_out_valid;
  assign alu_if.alu_out   = r_alu_out;
  assign alu_if.zero      = r_zero;
  assign alu_if.overflow  = r_overflow;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed and random stimulus for mips_alu with a queue of expected results.
// Latency: expectations are pushed at drive time and popped one cycle later.
// Backpressure: none exercised; the ALU accepts an op every cycle.
module tb_mips_alu;

  logic clk;
  logic rst_n;

  mips_alu_if #(.WIDTH(32)) bus ();

  mips_alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .alu_if (bus)
  );

  typedef struct {
    logic [31:0] out;
    logic        z;
    logic        o;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d expected to finish", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model written from the opcode table using widened signed arithmetic.
  task automatic model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] out, output logic ovf);
    logic signed [32:0] wide;
    out = 32'h0;
    ovf = 1'b0;
    case (ctl)
      4'b0000: out = a & b;
      4'b0001: out = a | b;
      4'b0010: begin
        wide = $signed({a[31], a}) + $signed({b[31], b});
        out  = wide[31:0];
        ovf  = wide[32] != wide[31];
      end
      4'b0110: begin
        wide = $signed({a[31], a}) - $signed({b[31], b});
        out  = wide[31:0];
        ovf  = wide[32] != wide[31];
      end
      4'b0111: out = (a[31] != b[31]) ? {31'h0, a[31]} : {31'h0, (a < b)};
      4'b1100: out = ~(a | b);
      default: begin
        out = 32'h0;
        ovf = 1'b0;
      end
    endcase
  endtask

  // Drive one op at the falling edge, push its expectation, then check after the rising edge.
  task automatic op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] e_out, input logic e_z,
                    input logic e_o);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctl  = ctl;
    bus.a        = a;
    bus.b        = b;
    e.out = e_out; e.z = e_z; e.o = e_o; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({got.tag, ".valid"}, {31'h0, bus.out_valid}, 32'h1);
      chk({got.tag, ".out"},   bus.alu_out,            got.out);
      chk({got.tag, ".zero"},  {31'h0, bus.zero},      {31'h0, got.z});
      chk({got.tag, ".ovf"},   {31'h0, bus.overflow},  {31'h0, got.o});
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rout, held;
    logic [3:0]  rctl;
    logic        rovf;
    logic [3:0]  ctl_tab [6];
    ctl_tab[0] = 4'b0000; ctl_tab[1] = 4'b0001; ctl_tab[2] = 4'b0010;
    ctl_tab[3] = 4'b0110; ctl_tab[4] = 4'b0111; ctl_tab[5] = 4'b1100;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_ctl  = 4'h0;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    #12;
    chk("rst.valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst.out",   bus.alu_out,            32'h0);
    chk("rst.zero",  {31'h0, bus.zero},      32'h1);
    chk("rst.ovf",   {31'h0, bus.overflow},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op("and1",  4'b0000, 32'h2,        32'hF,        32'h2,        1'b0, 1'b0);
    op("and2",  4'b0000, 32'h5,        32'hA,        32'h0,        1'b1, 1'b0);
    op("or1",   4'b0001, 32'h0,        32'hF,        32'hF,        1'b0, 1'b0);
    op("nor1",  4'b1100, 32'h8,        32'h5,        32'hFFFF_FFF2, 1'b0, 1'b0);
    op("nor2",  4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,      1'b1, 1'b0);
    op("add1",  4'b0010, 32'h8,        32'h5,        32'hD,        1'b0, 1'b0);
    op("add2",  4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op("add3",  4'b0010, 32'h7FFF_FFFF, 32'h1,      32'h8000_0000, 1'b0, 1'b1);
    op("undef", 4'b1010, 32'h1,        32'h8,        32'h0,        1'b1, 1'b0);
    op("sub1",  4'b0110, 32'hF,        32'h8,        32'h7,        1'b0, 1'b0);
    op("sub2",  4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,      1'b1, 1'b0);
    op("sub3",  4'b0110, 32'h8000_0000, 32'h1,      32'h7FFF_FFFF, 1'b0, 1'b1);
    op("and3",  4'b0000, 32'hFFFF_FFFF, 32'h1,      32'h1,        1'b0, 1'b0);
    op("slt1",  4'b0111, 32'h1,        32'h8,        32'h1,        1'b0, 1'b0);
    op("slt2",  4'b0111, 32'h8,        32'h5,        32'h0,        1'b1, 1'b0);
    op("slt3",  4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,      1'b1, 1'b0);
    op("slt4",  4'b0111, 32'hFFFF_FFFF, 32'h1,      32'h1,        1'b0, 1'b0);
    op("slt5",  4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,     1'b0, 1'b0);

    // Hold: result 0x1234 then two idle cycles with different operands on the bus.
    op("pre_hold", 4'b0001, 32'h1230, 32'h4, 32'h1234, 1'b0, 1'b0);
    held = 32'h1234;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.alu_ctl  = 4'b0010;
    bus.a        = 32'h7FFF_FFFF;
    bus.b        = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    chk("hold.valid", {31'h0, bus.out_valid}, 32'h0);
    chk("hold.out",   bus.alu_out,            held);
    chk("hold.zero",  {31'h0, bus.zero},      32'h0);
    chk("hold.ovf",   {31'h0, bus.overflow},  32'h0);

    // Random ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      rctl = ctl_tab[$urandom_range(0, 5)];
      ra   = $urandom;
      rb   = (i % 4 == 0) ? ra : $urandom;
      model(rctl, ra, rb, rout, rovf);
      op($sformatf("rnd%0d", i), rctl, ra, rb, rout, (rout == 32'h0), rovf);
    end

    // Asynchronous reset between edges clears outputs without a clock.
    op("pre_rst", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_ctl  = 4'b0001;
    bus.a        = 32'h55;
    bus.b        = 32'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'h0, bus.out_valid}, 32'h0);
    chk("arst.out",   bus.alu_out,            32'h0);
    chk("arst.zero",  {31'h0, bus.zero},      32'h1);
    chk("arst.ovf",   {31'h0, bus.overflow},  32'h0);
    // The in-flight OR is discarded: still cleared after the edge under reset.
    @(posedge clk);
    #1;
    chk("drop.valid", {31'h0, bus.out_valid}, 32'h0);
    chk("drop.out",   bus.alu_out,            32'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle.valid", {31'h0, bus.out_valid}, 32'h0);
    op("post_rst", 4'b0010, 32'h8, 32'h5, 32'hD, 1'b0, 1'b0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("sb.empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
